// File: rtl/dac_table_axim_dbg_pkg.sv
// Shared types and helpers for the dac_table_axim debug/monitor blocks.
package dac_table_axim_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATCH    = 2'd1,
    ST_DEADLOCK = 2'd2
  } mon_state_e;

  localparam logic [4:0] NO_CULPRIT = 5'd31;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_table_axim_prio_enc.sv
// Lowest-set-bit encoder with a valid flag; idx is 0 when nothing is set.
module dac_table_axim_prio_enc #(
  parameter int W     = 3,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      idx   = vec[i] ? IDX_W'(i) : idx;
      valid = valid | vec[i];
    end
  end

endmodule

// File: rtl/dac_table_axim_deadlock_monitor_n.sv
// Deadlock monitor for an HLS pipeline: filters persistent block conditions,
// latches a sticky report with culprit information and counts declarations.
module dac_table_axim_deadlock_monitor_n
  import dac_table_axim_dbg_pkg::*;
#(
  parameter int N_AXIS = 3,
  parameter int N_INST = 2,
  parameter int THRESH = 16,
  parameter int CNT_W  = 8,
  localparam int IW    = (N_INST > 0) ? N_INST : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [IW-1:0]     inst_idle_sigs,
  input  logic [IW-1:0]     inst_block_sigs,
  output logic              block,
  output logic              deadlock,
  output logic [N_AXIS-1:0] culprit_mask,
  output logic [4:0]        culprit_idx,
  output logic              inst_deadlock,
  output logic [CNT_W-1:0]  event_count
);

  localparam int RUN_W = clog2(THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESH - 1);

  if (N_AXIS < 1 || N_AXIS > 31) begin : g_axis_range_check
    $error("dac_table_axim_deadlock_monitor_n: N_AXIS must be in 1..31");
  end

  logic             inst_term_s;
  logic             axis_term_s;
  logic             raw_s;
  logic             declare_s;
  logic             release_s;
  logic [4:0]       enc_idx_s;
  logic             enc_valid_s;

  mon_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             block_q, block_d;
  logic             deadlock_q, deadlock_d;
  logic [N_AXIS-1:0] mask_q, mask_d;
  logic [4:0]       idx_q, idx_d;
  logic             inst_dl_q, inst_dl_d;
  logic [CNT_W-1:0] count_q, count_d;

  if (N_INST > 0) begin : g_inst_term
    assign inst_term_s = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
  end else begin : g_no_inst_term
    assign inst_term_s = 1'b0;
  end

  assign axis_term_s = |axis_block_sigs;
  assign raw_s       = enable & (axis_term_s | inst_term_s);

  dac_table_axim_prio_enc #(
    .W     (N_AXIS),
    .IDX_W (5)
  ) u_culprit_enc (
    .vec   (axis_block_sigs),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // Persistence filter FSM and next-state of the sticky report.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    declare_s = 1'b0;
    release_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (raw_s) begin
          if (THRESH == 1) begin
            state_d   = ST_DEADLOCK;
            declare_s = 1'b1;
            run_d     = {RUN_W{1'b0}};
          end else begin
            state_d = ST_WATCH;
            run_d   = RUN_W'(1);
          end
        end else begin
          run_d = {RUN_W{1'b0}};
        end
      end
      ST_WATCH: begin
        if (!raw_s) begin
          state_d = ST_IDLE;
          run_d   = {RUN_W{1'b0}};
        end else if (run_q == RUN_LAST) begin
          state_d   = ST_DEADLOCK;
          declare_s = 1'b1;
          run_d     = {RUN_W{1'b0}};
        end else if (run_q != {RUN_W{1'b1}}) begin
          run_d = run_q + RUN_W'(1);
        end else begin
          run_d = run_q;
        end
      end
      ST_DEADLOCK: begin
        if (clear) begin
          state_d   = ST_IDLE;
          release_s = 1'b1;
          run_d     = {RUN_W{1'b0}};
        end else begin
          state_d = ST_DEADLOCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = {RUN_W{1'b0}};
      end
    endcase

    block_d    = raw_s;
    deadlock_d = deadlock_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    inst_dl_d  = inst_dl_q;
    count_d    = count_q;
    if (declare_s) begin
      deadlock_d = 1'b1;
      mask_d     = axis_block_sigs;
      idx_d      = enc_valid_s ? enc_idx_s : NO_CULPRIT;
      inst_dl_d  = inst_term_s;
      count_d    = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    end else if (release_s) begin
      deadlock_d = 1'b0;
      mask_d     = {N_AXIS{1'b0}};
      idx_d      = NO_CULPRIT;
      inst_dl_d  = 1'b0;
    end else begin
      deadlock_d = deadlock_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_q      <= {RUN_W{1'b0}};
      block_q    <= 1'b0;
      deadlock_q <= 1'b0;
      mask_q     <= {N_AXIS{1'b0}};
      idx_q      <= NO_CULPRIT;
      inst_dl_q  <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      block_q    <= block_d;
      deadlock_q <= deadlock_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      inst_dl_q  <= inst_dl_d;
      count_q    <= count_d;
    end
  end

  assign block         = block_q;
  assign deadlock      = deadlock_q;
  assign culprit_mask  = mask_q;
  assign culprit_idx   = idx_q;
  assign inst_deadlock = inst_dl_q;
  assign event_count   = count_q;

endmodule

// File: tb/tb_dac_table_axim_deadlock_monitor_n.sv
// Bench: two monitors (THRESH=16/CNT_W=2 and THRESH=1/CNT_W=8) on shared
// stimulus, checked against a streak-counting reference model.
module tb_dac_table_axim_deadlock_monitor_n;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b1;
  logic       clr   = 1'b0;
  logic [2:0] axis  = 3'b000;
  logic [1:0] idle  = 2'b00;
  logic [1:0] blk   = 2'b00;

  logic       block_a, dl_a, inst_a;
  logic [2:0] mask_a;
  logic [4:0] idx_a;
  logic [1:0] cnt_a;
  logic       block_b, dl_b, inst_b;
  logic [2:0] mask_b;
  logic [4:0] idx_b;
  logic [7:0] cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = DUT A, index 1 = DUT B.
  int         thr[2]  = '{16, 1};
  int         cmax[2] = '{3, 255};
  logic       m_block[2];
  logic       m_dl[2];
  logic [2:0] m_mask[2];
  int         m_idx[2];
  logic       m_inst[2];
  int         m_cnt[2];
  int         m_streak[2];

  logic [12:0] exp_a;
  logic [18:0] exp_b;
  wire  [12:0] obs_a = {block_a, dl_a, mask_a, idx_a, inst_a, cnt_a};
  wire  [18:0] obs_b = {block_b, dl_b, mask_b, idx_b, inst_b, cnt_b};

  always #5 clock = ~clock;

  dac_table_axim_deadlock_monitor_n #(.N_AXIS(3), .N_INST(2), .THRESH(16), .CNT_W(2)) u_dut_a (
    .clock(clock), .reset(reset), .enable(en), .clear(clr),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_a), .deadlock(dl_a), .culprit_mask(mask_a), .culprit_idx(idx_a),
    .inst_deadlock(inst_a), .event_count(cnt_a));

  dac_table_axim_deadlock_monitor_n #(.N_AXIS(3), .N_INST(2), .THRESH(1), .CNT_W(8)) u_dut_b (
    .clock(clock), .reset(reset), .enable(en), .clear(clr),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_b), .deadlock(dl_b), .culprit_mask(mask_b), .culprit_idx(idx_b),
    .inst_deadlock(inst_b), .event_count(cnt_b));

  function automatic int lowest_bit(input logic [2:0] v);
    for (int i = 0; i < 3; i++) begin
      if (v[i]) return i;
    end
    return 31;
  endfunction

  // One clock edge: update model from pre-edge inputs, then settle 1 time unit.
  task automatic tick();
    logic inst_t, raw_t;
    inst_t = (&(idle | blk)) && (|blk);
    raw_t  = en && ((|axis) || inst_t);
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_block[d] = 1'b0; m_dl[d] = 1'b0; m_mask[d] = 3'b000; m_idx[d] = 31;
        m_inst[d] = 1'b0; m_cnt[d] = 0; m_streak[d] = 0;
      end else begin
        m_block[d] = raw_t;
        if (m_dl[d]) begin
          if (clr) begin
            m_dl[d] = 1'b0; m_mask[d] = 3'b000; m_idx[d] = 31; m_inst[d] = 1'b0;
            m_streak[d] = 0;
          end
        end else if (raw_t) begin
          m_streak[d] = m_streak[d] + 1;
          if (m_streak[d] >= thr[d]) begin
            m_dl[d] = 1'b1; m_mask[d] = axis; m_idx[d] = lowest_bit(axis);
            m_inst[d] = inst_t; m_streak[d] = 0;
            if (m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
          end
        end else begin
          m_streak[d] = 0;
        end
      end
    end
    exp_a = {m_block[0], m_dl[0], m_mask[0], 5'(m_idx[0]), m_inst[0], 2'(m_cnt[0])};
    exp_b = {m_block[1], m_dl[1], m_mask[1], 5'(m_idx[1]), m_inst[1], 8'(m_cnt[1])};
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; clr = 1'b0; axis = 3'b000; idle = 2'b00; blk = 2'b00;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_a !== 13'b0_0_000_11111_0_00) begin
      bad++; $display("FAIL reset_a got=%h want=%h", obs_a, 13'b0_0_000_11111_0_00);
    end
    total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL reset_b got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_pulse_burst();
    do_reset();
    axis = 3'b010;
    for (int k = 0; k < 15; k++) begin
      tick();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL burst_a cyc=%0d got=%h want=%h", k, obs_a, exp_a); end
    end
    axis = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL burst_b cyc=%0d got=%h want=%h", k, obs_b, exp_b); end
    end
    total++;
    if ({block_a, dl_a, cnt_a} !== 4'b0_0_00) begin
      bad++; $display("FAIL burst_nodl got=%b want=0000", {block_a, dl_a, cnt_a});
    end
  endtask

  task automatic test_persistent();
    do_reset();
    axis = 3'b110;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL persist_a cyc=%0d got=%h want=%h", k, obs_a, exp_a); end
      if (k == 15) begin
        total++;
        if (dl_a !== 1'b0) begin bad++; $display("FAIL persist_early got=%b want=0", dl_a); end
      end
    end
    total++;
    if ({dl_a, mask_a, idx_a, cnt_a} !== {1'b1, 3'b110, 5'd1, 2'd1}) begin
      bad++; $display("FAIL persist_decl got=%b want=%b", {dl_a, mask_a, idx_a, cnt_a}, {1'b1, 3'b110, 5'd1, 2'd1});
    end
    for (int k = 0; k < 8; k++) begin
      axis = 3'($urandom_range(0, 7));
      tick();
      total++;
      if ({dl_a, mask_a, idx_a} !== {1'b1, 3'b110, 5'd1}) begin
        bad++; $display("FAIL persist_hold got=%b want=%b", {dl_a, mask_a, idx_a}, {1'b1, 3'b110, 5'd1});
      end
    end
  endtask

  task automatic test_inst_only();
    do_reset();
    idle = 2'b01; blk = 2'b10;
    for (int k = 0; k < 16; k++) tick();
    total++;
    if ({dl_a, inst_a, idx_a, mask_a} !== {1'b1, 1'b1, 5'd31, 3'b000}) begin
      bad++; $display("FAIL inst_decl got=%b want=%b", {dl_a, inst_a, idx_a, mask_a}, {1'b1, 1'b1, 5'd31, 3'b000});
    end
    total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL inst_b got=%h want=%h", obs_b, exp_b); end
    do_reset();
    idle = 2'b00; blk = 2'b10;
    for (int k = 0; k < 20; k++) tick();
    total++;
    if ({block_a, dl_a, block_b, dl_b} !== 4'b0000) begin
      bad++; $display("FAIL inst_never got=%b want=0000", {block_a, dl_a, block_b, dl_b});
    end
  endtask

  task automatic test_clear_rearm();
    do_reset();
    axis = 3'b001;
    for (int k = 0; k < 16; k++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    total++;
    if (dl_a !== 1'b0 || idx_a !== 5'd31) begin
      bad++; $display("FAIL clear_rel got=%b/%0d want=0/31", dl_a, idx_a);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL rearm_a cyc=%0d got=%h want=%h", k, obs_a, exp_a); end
    end
    total++;
    if ({dl_a, cnt_a} !== {1'b1, 2'd2}) begin
      bad++; $display("FAIL rearm_cnt got=%b want=%b", {dl_a, cnt_a}, {1'b1, 2'd2});
    end
    for (int r = 0; r < 3; r++) begin
      clr = 1'b1; tick(); clr = 1'b0;
      for (int k = 0; k < 16; k++) tick();
    end
    total++;
    if ({dl_a, cnt_a} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL sat_cnt got=%b want=%b", {dl_a, cnt_a}, {1'b1, 2'd3});
    end
    total++;
    if (obs_b !== exp_b) begin bad++; $display("FAIL rearm_b got=%h want=%h", obs_b, exp_b); end
  endtask

  task automatic test_thresh1();
    do_reset();
    axis = 3'b010;
    tick();
    axis = 3'b000;
    total++;
    if ({dl_b, idx_b, cnt_b} !== {1'b1, 5'd1, 8'd1}) begin
      bad++; $display("FAIL thr1_decl got=%b want=%b", {dl_b, idx_b, cnt_b}, {1'b1, 5'd1, 8'd1});
    end
  endtask

  task automatic test_enable_abort();
    do_reset();
    axis = 3'b100;
    for (int k = 0; k < 10; k++) begin
      clr = (k == 5) ? 1'b1 : 1'b0;
      tick();
    end
    clr = 1'b0;
    en = 1'b0; tick(); en = 1'b1;
    total++;
    if ({block_a, dl_a} !== 2'b00) begin bad++; $display("FAIL en_abort got=%b want=00", {block_a, dl_a}); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL reen_a cyc=%0d got=%h want=%h", k, obs_a, exp_a); end
    end
    total++;
    if (dl_a !== 1'b1) begin bad++; $display("FAIL reen_decl got=%b want=1", dl_a); end
  endtask

  task automatic test_reset_mid_deadlock();
    do_reset();
    axis = 3'b111;
    for (int k = 0; k < 20; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (obs_a !== 13'b0_0_000_11111_0_00) begin
      bad++; $display("FAIL rst_dl_a got=%h want=%h", obs_a, 13'b0_0_000_11111_0_00);
    end
    total++;
    if (obs_b !== 19'b0_0_000_11111_0_00000000) begin
      bad++; $display("FAIL rst_dl_b got=%h want=%h", obs_b, 19'b0_0_000_11111_0_00000000);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) axis = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin idle = 2'($urandom); blk = 2'($urandom); end
      en    = ($urandom_range(0, 29) != 0);
      clr   = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL rand_a cyc=%0d got=%h want=%h", k, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL rand_b cyc=%0d got=%h want=%h", k, obs_b, exp_b); end
    end
    reset = 1'b0; clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pulse_burst();
    test_persistent();
    test_inst_only();
    test_clear_rearm();
    test_thresh1();
    test_enable_abort();
    test_reset_mid_deadlock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
